// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and constants for the capture sequencing block
// Purpose : state encoding and trigger-source codes used by capture_controller.
// Contents: capture_state_t, TRIG_LEVEL, TRIG_EXT, cnt_width().
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        HOLDOFF = 2'd3
    } capture_state_t;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EXT   = 1'b1;

    // One counter serves both the capture window and the hold-off window,
    // so it is sized for whichever of the two is longer.
    function automatic int cnt_width(input int length, input int holdoff);
        int m;
        m = (length > holdoff) ? length : holdoff;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/trigger_detect.sv
// rtl/trigger_detect.sv - signed rising level-crossing detector on one selected input bus
// Purpose : flags the cycle where the selected bus crosses the threshold upward.
// Ports   : sink_clk, reset        clock and synchronous active-high reset
//           chan                   bus index to watch
//           level                  signed threshold
//           sink_data[0:NSINK-1]   input buses (signed samples)
//           fire                   combinational: prev < level && cur >= level
module trigger_detect #(
    parameter int NSINK = 4,
    parameter int WIDTH = 16
) (
    input  logic                       sink_clk,
    input  logic                       reset,
    input  logic [$clog2(NSINK)-1:0]   chan,
    input  logic signed [WIDTH-1:0]    level,
    input  logic [WIDTH-1:0]           sink_data [0:NSINK-1],
    output logic                       fire
);

    // Previous samples are kept for every bus, so a channel change on arm
    // compares against that channel's own history rather than another bus.
    logic [WIDTH-1:0] prev_q [0:NSINK-1];
    logic [WIDTH-1:0] prev_d [0:NSINK-1];
    logic             valid_q;
    logic             valid_d;

    logic signed [WIDTH-1:0] cur_s;
    logic signed [WIDTH-1:0] prev_s;

    always_comb begin
        for (int i = 0; i < NSINK; i++) begin
            prev_d[i] = sink_data[i];
        end
        valid_d = 1'b1;
    end

    always_ff @(posedge sink_clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // prev_q needs no reset: valid_q masks it until it holds a real sample.
    always_ff @(posedge sink_clk) begin
        for (int i = 0; i < NSINK; i++) begin
            prev_q[i] <= prev_d[i];
        end
    end

    always_comb begin
        cur_s  = $signed(sink_data[chan]);
        prev_s = $signed(prev_q[chan]);
        fire   = valid_q && (prev_s < level) && (cur_s >= level);
    end

endmodule

// File: rtl/capture_controller.sv
// rtl/capture_controller.sv - arm/trigger/capture/hold-off sequencer driving input_buffer
// Purpose : arms on command, waits for a level or external trigger, pulses
//           buf_start, then holds off long enough for the buffer to drain.
// Ports   : sink_clk, reset                    clock, synchronous active-high reset
//           arm, abort                         command pulses
//           continuous, trig_src, trig_chan,
//           trig_level                         configuration, latched on accepted arm
//           ext_trig                           external trigger (sink_clk domain)
//           sink_data[0:NSINK-1]               buses feeding the buffer
//           buf_start                          one-cycle start pulse to the buffer
//           armed, busy, run_count, missed     registered status
module capture_controller
    import capture_pkg::*;
#(
    parameter int NSINK   = 4,
    parameter int WIDTH   = 16,
    parameter int LENGTH  = 1024,
    parameter int HOLDOFF = 8192
) (
    input  logic                     sink_clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     continuous,
    input  logic                     trig_src,
    input  logic [$clog2(NSINK)-1:0] trig_chan,
    input  logic [WIDTH-1:0]         trig_level,
    input  logic                     ext_trig,
    input  logic [WIDTH-1:0]         sink_data [0:NSINK-1],
    output logic                     buf_start,
    output logic                     armed,
    output logic                     busy,
    output logic [15:0]              run_count,
    output logic                     missed
);

    localparam int CNT_W  = cnt_width(LENGTH, HOLDOFF);
    localparam int CHAN_W = $clog2(NSINK);

    localparam logic [CNT_W-1:0] LEN_LOAD  = CNT_W'(LENGTH - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

    capture_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cont_q, cont_d;
    logic              src_q, src_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic [WIDTH-1:0]  level_q, level_d;
    logic [15:0]       run_count_q, run_count_d;
    logic              missed_q, missed_d;
    logic              buf_start_q, buf_start_d;
    logic              armed_q, armed_d;
    logic              busy_q, busy_d;

    logic level_fire;
    logic trig;

    trigger_detect #(
        .NSINK (NSINK),
        .WIDTH (WIDTH)
    ) u_trigger_detect (
        .sink_clk  (sink_clk),
        .reset     (reset),
        .chan      (chan_q),
        .level     ($signed(level_q)),
        .sink_data (sink_data),
        .fire      (level_fire)
    );

    assign trig = (src_q == TRIG_EXT) ? ext_trig : level_fire;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cont_d      = cont_q;
        src_d       = src_q;
        chan_d      = chan_q;
        level_d     = level_q;
        run_count_d = run_count_q;
        missed_d    = missed_q;
        buf_start_d = 1'b0;

        unique case (state_q)
            capture_pkg::IDLE: begin
                if (arm && !abort) begin
                    cont_d      = continuous;
                    src_d       = trig_src;
                    chan_d      = trig_chan;
                    level_d     = trig_level;
                    run_count_d = 16'd0;
                    missed_d    = 1'b0;
                    state_d     = capture_pkg::ARMED;
                end
            end
            capture_pkg::ARMED: begin
                if (abort) begin
                    state_d = capture_pkg::IDLE;
                end else if (trig) begin
                    buf_start_d = 1'b1;
                    cnt_d       = LEN_LOAD;
                    state_d     = capture_pkg::CAPTURE;
                end
            end
            capture_pkg::CAPTURE: begin
                // The buffer cannot be stopped mid-run, so abort only
                // prevents the automatic re-arm.
                if (abort) begin
                    cont_d = 1'b0;
                end
                if (trig) begin
                    missed_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = capture_pkg::HOLDOFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            capture_pkg::HOLDOFF: begin
                if (abort) begin
                    cont_d = 1'b0;
                end
                if (trig) begin
                    missed_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    run_count_d = run_count_q + 16'd1;
                    // cont_d so an abort on the very last cycle still ends in IDLE.
                    state_d     = cont_d ? capture_pkg::ARMED : capture_pkg::IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = capture_pkg::IDLE;
            end
        endcase

        armed_d = (state_d == capture_pkg::ARMED);
        busy_d  = (state_d != capture_pkg::IDLE);
    end

    always_ff @(posedge sink_clk) begin
        if (reset) begin
            state_q     <= capture_pkg::IDLE;
            cnt_q       <= '0;
            cont_q      <= 1'b0;
            src_q       <= TRIG_LEVEL;
            chan_q      <= '0;
            level_q     <= '0;
            run_count_q <= 16'd0;
            missed_q    <= 1'b0;
            buf_start_q <= 1'b0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cont_q      <= cont_d;
            src_q       <= src_d;
            chan_q      <= chan_d;
            level_q     <= level_d;
            run_count_q <= run_count_d;
            missed_q    <= missed_d;
            buf_start_q <= buf_start_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
        end
    end

    assign buf_start = buf_start_q;
    assign armed     = armed_q;
    assign busy      = busy_q;
    assign run_count = run_count_q;
    assign missed    = missed_q;

endmodule

// File: tb/tb_capture_controller.sv
// tb/tb_capture_controller.sv - self-checking bench for capture_controller
module tb_capture_controller;

    localparam int NS   = 4;
    localparam int W    = 16;
    localparam int LEN  = 8;
    localparam int HOLD = 16;
    localparam int PER  = LEN + HOLD + 1;

    logic          sink_clk = 1'b0;
    logic          reset;
    logic          arm;
    logic          abort;
    logic          continuous;
    logic          trig_src;
    logic [1:0]    trig_chan;
    logic [W-1:0]  trig_level;
    logic          ext_trig;
    logic [W-1:0]  sink_data [0:NS-1];
    logic          buf_start;
    logic          armed;
    logic          busy;
    logic [15:0]   run_count;
    logic          missed;

    int total = 0;
    int bad   = 0;

    capture_controller #(
        .NSINK   (NS),
        .WIDTH   (W),
        .LENGTH  (LEN),
        .HOLDOFF (HOLD)
    ) dut (
        .sink_clk   (sink_clk),
        .reset      (reset),
        .arm        (arm),
        .abort      (abort),
        .continuous (continuous),
        .trig_src   (trig_src),
        .trig_chan  (trig_chan),
        .trig_level (trig_level),
        .ext_trig   (ext_trig),
        .sink_data  (sink_data),
        .buf_start  (buf_start),
        .armed      (armed),
        .busy       (busy),
        .run_count  (run_count),
        .missed     (missed)
    );

    always #5 sink_clk = ~sink_clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a sequence is "on" from an accepted arm until it
    // finishes; a triggered run occupies a fixed window of LEN+HOLD cycles
    // after the trigger cycle, ending at cycle m_run_end.
    int m_cyc = 0;
    bit m_on = 0, m_cont = 0, m_src = 0, m_valid = 0, m_missed = 0;
    int m_chan = 0, m_lvl = 0, m_runs = 0, m_run_end = -1;
    int m_prev [0:NS-1];
    bit e_bs = 0, e_armed = 0, e_busy = 0;
    bit mon_en = 1;

    task automatic model_step();
        int cur [0:NS-1];
        bit trig;
        bit in_run;
        for (int i = 0; i < NS; i++) cur[i] = int'($signed(sink_data[i]));
        if (m_src) trig = ext_trig;
        else       trig = m_valid && (m_prev[m_chan] < m_lvl) && (cur[m_chan] >= m_lvl);
        if (reset) begin
            m_on = 0; m_run_end = -1; m_runs = 0; m_missed = 0;
            m_valid = 0; m_cont = 0; e_bs = 0;
        end else begin
            e_bs = 0;
            in_run = m_on && (m_cyc <= m_run_end);
            if (!m_on) begin
                if (arm && !abort) begin
                    m_cont = continuous; m_src = trig_src;
                    m_chan = int'(trig_chan); m_lvl = int'($signed(trig_level));
                    m_runs = 0; m_missed = 0; m_on = 1; m_run_end = -1;
                end
            end else if (!in_run) begin
                if (abort) m_on = 0;
                else if (trig) begin
                    e_bs = 1;
                    m_run_end = m_cyc + LEN + HOLD;
                end
            end else begin
                if (abort) m_cont = 0;
                if (trig) m_missed = 1;
                if (m_cyc == m_run_end) begin
                    m_runs = (m_runs + 1) % 65536;
                    if (!m_cont) m_on = 0;
                end
            end
            for (int i = 0; i < NS; i++) m_prev[i] = cur[i];
            m_valid = 1;
        end
        m_cyc++;
        e_busy  = m_on;
        e_armed = m_on && !(m_cyc <= m_run_end);
    endtask

    always @(posedge sink_clk) model_step();

    always @(negedge sink_clk) begin
        if (mon_en && m_cyc > 0) begin
            chk("mon_buf_start", int'(buf_start), int'(e_bs));
            chk("mon_armed",     int'(armed),     int'(e_armed));
            chk("mon_busy",      int'(busy),      int'(e_busy));
            chk("mon_run_count", int'(run_count), m_runs);
            chk("mon_missed",    int'(missed),    int'(m_missed));
        end
    end

    task automatic step();
        @(posedge sink_clk);
        @(negedge sink_clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", int'(busy), 0);
    endtask

    typedef struct {
        int arm, abort, cont, src, chan, lvl, ext, d2;
        int bs, armed, busy, missed, rc;
    } vec_t;

    vec_t tbl [0:8];

    initial begin
        int nb, extra, bs_first, busy_cnt, rc_at4;
        int bs_at [0:3];

        tbl[0] = '{1, 1, 0, 0, 2, 100, 0,  50,  0, 0, 0, 0, 0}; // arm+abort in IDLE
        tbl[1] = '{0, 0, 0, 0, 2, 100, 0,  50,  0, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 2, 100, 0,  50,  0, 1, 1, 0, 0}; // arm
        tbl[3] = '{0, 1, 0, 0, 2, 100, 0,  50,  0, 0, 0, 0, 0}; // abort in ARMED
        tbl[4] = '{1, 0, 0, 0, 2, 100, 0,  99,  0, 1, 1, 0, 0};
        tbl[5] = '{0, 1, 0, 0, 2, 100, 0, 150,  0, 0, 0, 0, 0}; // trigger+abort
        tbl[6] = '{1, 0, 0, 0, 2,   0, 0,  -1,  0, 1, 1, 0, 0}; // level 0
        tbl[7] = '{0, 0, 0, 0, 2,   0, 0,   0,  1, 0, 1, 0, 0}; // -1 -> 0 fires
        tbl[8] = '{1, 0, 0, 0, 2,   5, 0,   0,  0, 0, 1, 0, 0}; // arm ignored

        reset = 1; arm = 0; abort = 0; continuous = 0; trig_src = 0;
        trig_chan = 0; trig_level = 0; ext_trig = 0;
        for (int i = 0; i < NS; i++) sink_data[i] = 16'd500;
        repeat (3) step();
        chk("reset_buf_start", int'(buf_start), 0);
        chk("reset_armed",     int'(armed), 0);
        chk("reset_busy",      int'(busy), 0);
        chk("reset_run_count", int'(run_count), 0);
        chk("reset_missed",    int'(missed), 0);
        reset = 0;
        step();

        for (int r = 0; r <= 8; r++) begin
            arm = tbl[r].arm[0]; abort = tbl[r].abort[0];
            continuous = tbl[r].cont[0]; trig_src = tbl[r].src[0];
            trig_chan = 2'(tbl[r].chan); trig_level = 16'(tbl[r].lvl);
            ext_trig = tbl[r].ext[0]; sink_data[2] = 16'(tbl[r].d2);
            step();
            chk($sformatf("vec%0d_buf_start", r), int'(buf_start), tbl[r].bs);
            chk($sformatf("vec%0d_armed", r),     int'(armed),     tbl[r].armed);
            chk($sformatf("vec%0d_busy", r),      int'(busy),      tbl[r].busy);
            chk($sformatf("vec%0d_missed", r),    int'(missed),    tbl[r].missed);
            chk($sformatf("vec%0d_run_count", r), int'(run_count), tbl[r].rc);
        end
        arm = 0; abort = 0;
        wait_idle(100);

        // Single shot, level trigger on bus 2, 99 -> 100 at cycle t.
        sink_data[2] = 16'd99;
        arm = 1; continuous = 0; trig_src = 0; trig_chan = 2; trig_level = 16'd100;
        step();
        arm = 0;
        step();
        sink_data[2] = 16'd100;
        nb = 0; bs_first = -1; busy_cnt = 0;
        for (int i = 0; i < PER + 6; i++) begin
            if (busy) busy_cnt++;
            if (buf_start) begin
                nb++;
                if (bs_first < 0) bs_first = i;
            end
            step();
        end
        chk("single_bs_count", nb, 1);
        chk("single_bs_cycle", bs_first, 1);
        chk("single_busy_cycles", busy_cnt, PER);
        chk("single_end_idle", int'(busy), 0);
        chk("single_run_count", int'(run_count), 1);

        // Continuous, external trigger held high.
        arm = 1; continuous = 1; trig_src = 1; ext_trig = 1;
        step();
        arm = 0;
        nb = 0; rc_at4 = -1;
        for (int i = 0; i < 5 * PER && nb < 4; i++) begin
            if (buf_start) begin
                bs_at[nb] = i;
                if (nb == 3) rc_at4 = int'(run_count);
                nb++;
            end
            if (nb < 4) step();
        end
        chk("cont_pulses_seen", nb, 4);
        for (int k = 1; k < 4; k++) chk($sformatf("cont_gap%0d", k), bs_at[k] - bs_at[k-1], PER);
        chk("cont_run_count_3", rc_at4, 3);
        // Abort in CAPTURE of a continuous run: run completes, then IDLE.
        step();
        abort = 1;
        step();
        abort = 0;
        extra = 0;
        for (int i = 0; i < PER + 5 && busy; i++) begin
            if (buf_start) extra++;
            step();
        end
        chk("abort_cap_extra_bs", extra, 0);
        chk("abort_cap_idle", int'(busy), 0);
        chk("abort_cap_run_count", int'(run_count), 4);
        ext_trig = 0;

        // Missed trigger during HOLDOFF.
        arm = 1; continuous = 0; trig_src = 1;
        step();
        arm = 0;
        ext_trig = 1;
        step();
        ext_trig = 0;
        chk("miss_bs", int'(buf_start), 1);
        chk("miss_clear_before", int'(missed), 0);
        repeat (LEN + 3) step();
        ext_trig = 1;
        step();
        ext_trig = 0;
        chk("miss_set", int'(missed), 1);
        extra = 0;
        for (int i = 0; i < PER && busy; i++) begin
            if (buf_start) extra++;
            step();
        end
        chk("miss_extra_bs", extra, 0);
        chk("miss_idle", int'(busy), 0);
        chk("miss_sticky", int'(missed), 1);
        chk("miss_run_count", int'(run_count), 1);
        arm = 1; trig_src = 0; trig_chan = 0; trig_level = 16'd1000;
        step();
        arm = 0;
        chk("rearm_clears_missed", int'(missed), 0);
        chk("rearm_clears_count", int'(run_count), 0);
        chk("rearm_armed", int'(armed), 1);
        abort = 1;
        step();
        abort = 0;
        chk("abort_armed_idle", int'(busy), 0);

        // Reset mid-HOLDOFF.
        arm = 1; continuous = 1; trig_src = 1;
        step();
        arm = 0;
        ext_trig = 1;
        step();
        ext_trig = 0;
        step();
        ext_trig = 1;
        step();
        ext_trig = 0;
        repeat (LEN + 2) step();
        chk("rst_pre_busy", int'(busy), 1);
        chk("rst_pre_missed", int'(missed), 1);
        reset = 1;
        step();
        reset = 0;
        chk("rst_mid_buf_start", int'(buf_start), 0);
        chk("rst_mid_armed", int'(armed), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_run_count", int'(run_count), 0);
        chk("rst_mid_missed", int'(missed), 0);
        arm = 1; continuous = 0; trig_src = 0; trig_chan = 1; trig_level = 16'd10;
        step();
        arm = 0;
        chk("rst_then_arm", int'(armed), 1);
        abort = 1;
        step();
        abort = 0;

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            int v;
            arm        = ($urandom_range(0, 11) == 0);
            abort      = ($urandom_range(0, 39) == 0);
            continuous = 1'($urandom_range(0, 1));
            trig_src   = 1'($urandom_range(0, 1));
            trig_chan  = 2'($urandom_range(0, 3));
            v          = int'($urandom_range(0, 4)) - 2;
            trig_level = 16'(v);
            ext_trig   = ($urandom_range(0, 14) == 0);
            reset      = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NS; i++) begin
                v = int'($urandom_range(0, 6)) - 3;
                sink_data[i] = 16'(v);
            end
            step();
        end
        reset = 0; arm = 0; abort = 0; ext_trig = 0;
        step();
        mon_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
